// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-prefixed little-endian word
// stream, writes each word to instruction memory and releases the core on a good checksum.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_count;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_word_idx;
    logic [7:0]  r_csum;
    logic [23:0] r_word;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_rx_ready;
    logic        w_accept;
    logic        w_last_byte;
    logic        w_last_word;
    logic        w_restart_ok;
    logic [31:0] w_count_next;
    logic [31:0] w_word_full;

    assign w_rx_ready   = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_accept     = rx_valid && w_rx_ready;
    assign w_last_byte  = (r_byte_cnt == 2'd3);
    assign w_last_word  = (r_word_idx == (r_count - 32'd1));
    assign w_restart_ok = restart && ((r_state == S_DONE) || (r_state == S_ERR));

    // Bytes arrive least-significant first, so shifting in from the top leaves byte 0 in [7:0].
    assign w_count_next = {rx_data, r_count[31:8]};
    assign w_word_full  = {rx_data, r_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LEN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN: begin
                if (w_accept && w_last_byte) begin
                    if (w_count_next > DEPTH_LIMIT) begin
                        w_next = S_ERR;
                    end else if (w_count_next == 32'd0) begin
                        w_next = S_CSUM;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && w_last_byte && w_last_word) begin
                    w_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_next = (rx_data == r_csum) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                if (restart) begin
                    w_next = S_LEN;
                end
            end
            S_ERR: begin
                if (restart) begin
                    w_next = S_LEN;
                end
            end
            default: begin
                w_next = S_LEN;
            end
        endcase
    end

    // The write strobe is registered, so it appears the cycle after the last byte of a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= 32'd0;
            r_byte_cnt <= 2'd0;
            r_word_idx <= 32'd0;
            r_csum     <= 8'd0;
            r_word     <= 24'd0;
            r_we       <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_wdata    <= 32'd0;
        end else begin
            r_we <= 1'b0;
            if (w_restart_ok) begin
                r_count    <= 32'd0;
                r_byte_cnt <= 2'd0;
                r_word_idx <= 32'd0;
                r_csum     <= 8'd0;
                r_word     <= 24'd0;
            end else if (w_accept) begin
                case (r_state)
                    S_LEN: begin
                        r_count    <= w_count_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                    S_DATA: begin
                        r_word     <= w_word_full[31:8];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_csum     <= r_csum ^ rx_data;
                        if (w_last_byte) begin
                            r_we       <= 1'b1;
                            r_addr     <= BASE_ADDR + {r_word_idx[29:0], 2'b00};
                            r_wdata    <= w_word_full;
                            r_word_idx <= r_word_idx + 32'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rx_ready   = w_rx_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_hold  = (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default instance (base 0, depth 1024) and a small
// instance (base 0x1000, depth 4) for the size limit, restart and non-zero base cases.
module tb_imem_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n0, rx_valid0, restart0, ready0, we0, hold0, done0, err0;
    logic [7:0]  rx_data0;
    logic [31:0] addr0, wdata0;

    logic        rst_n4, rx_valid4, restart4, ready4, we4, hold4, done4, err4;
    logic [7:0]  rx_data4;
    logic [31:0] addr4, wdata4;

    int checks = 0;
    int errors = 0;

    logic [31:0] q0_addr[$];
    logic [31:0] q0_data[$];
    logic [31:0] q4_addr[$];
    logic [31:0] q4_data[$];

    imem_loader dut0 (
        .clk(clk), .rst_n(rst_n0), .rx_valid(rx_valid0), .rx_data(rx_data0),
        .rx_ready(ready0), .restart(restart0), .imem_we(we0), .imem_addr(addr0),
        .imem_wdata(wdata0), .core_hold(hold0), .done(done0), .err(err0)
    );

    imem_loader #(.BASE_ADDR(32'h0000_1000), .DEPTH_WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .rx_valid(rx_valid4), .rx_data(rx_data4),
        .rx_ready(ready4), .restart(restart4), .imem_we(we4), .imem_addr(addr4),
        .imem_wdata(wdata4), .core_hold(hold4), .done(done4), .err(err4)
    );

    // Every cycle with the write strobe high logs one write, so a stretched strobe shows up as extras.
    always @(negedge clk) begin
        if (we0) begin
            q0_addr.push_back(addr0);
            q0_data.push_back(wdata0);
        end
        if (we4) begin
            q4_addr.push_back(addr4);
            q4_data.push_back(wdata4);
        end
    end

    function automatic logic [7:0] xor_word(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b);
        if (sel) begin
            rx_valid4 = 1'b1;
            rx_data4  = b;
        end else begin
            rx_valid0 = 1'b1;
            rx_data0  = b;
        end
        @(posedge clk);
        #1;
        rx_valid0 = 1'b0;
        rx_valid4 = 1'b0;
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w);
        send_byte(sel, w[7:0]);
        send_byte(sel, w[15:8]);
        send_byte(sel, w[23:16]);
        send_byte(sel, w[31:24]);
    endtask

    task automatic pulse_restart(input bit sel);
        if (sel) restart4 = 1'b1;
        else     restart0 = 1'b1;
        @(posedge clk);
        #1;
        restart0 = 1'b0;
        restart4 = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (ready0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready0: got %0b expected 1", ready0); end
        checks++; if (we0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_we0: got %0b expected 0", we0); end
        checks++; if (addr0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr0: got %h expected 00000000", addr0); end
        checks++; if (wdata0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata0: got %h expected 00000000", wdata0); end
        checks++; if ({hold0, done0, err0} !== 3'b100) begin errors++; $display("[TB] FAIL reset_status0: got hold/done/err %b expected 100", {hold0, done0, err0}); end
        checks++; if (addr4 !== 32'h0000_1000) begin errors++; $display("[TB] FAIL reset_addr4: got %h expected 00001000", addr4); end
        checks++; if ({hold4, done4, err4} !== 3'b100) begin errors++; $display("[TB] FAIL reset_status4: got hold/done/err %b expected 100", {hold4, done4, err4}); end
    endtask

    task automatic test_single_word;
        q0_addr.delete(); q0_data.delete();
        send_word(0, 32'd1);
        send_word(0, 32'h0000_0013);
        checks++; if (we0 !== 1'b1) begin errors++; $display("[TB] FAIL single_we_pulse: got %0b expected 1", we0); end
        checks++; if (addr0 !== 32'h0) begin errors++; $display("[TB] FAIL single_addr: got %h expected 00000000", addr0); end
        checks++; if (wdata0 !== 32'h0000_0013) begin errors++; $display("[TB] FAIL single_wdata: got %h expected 00000013", wdata0); end
        send_byte(0, 8'h13);
        checks++; if (we0 !== 1'b0) begin errors++; $display("[TB] FAIL single_we_one_cycle: got %0b expected 0", we0); end
        checks++; if ({hold0, done0, err0, ready0} !== 4'b0100) begin errors++; $display("[TB] FAIL single_done: got hold/done/err/ready %b expected 0100", {hold0, done0, err0, ready0}); end
        send_byte(0, 8'hFF);
        send_byte(0, 8'h00);
        checks++; if (done0 !== 1'b1 || q0_addr.size() != 1) begin errors++; $display("[TB] FAIL done_ignores_rx: got done %0b writes %0d expected 1 and 1", done0, q0_addr.size()); end
        checks++; if (wdata0 !== 32'h0000_0013) begin errors++; $display("[TB] FAIL single_hold_wdata: got %h expected 00000013", wdata0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] cs;
        cs = xor_word(32'h0050_0093) ^ xor_word(32'h00A0_0113);
        pulse_restart(0);
        checks++; if ({hold0, done0, ready0} !== 3'b101) begin errors++; $display("[TB] FAIL b2b_restart: got hold/done/ready %b expected 101", {hold0, done0, ready0}); end
        q0_addr.delete(); q0_data.delete();
        send_word(0, 32'd2);
        send_word(0, 32'h0050_0093);
        send_word(0, 32'h00A0_0113);
        send_byte(0, cs);
        idle(1);
        checks++; if (q0_addr.size() != 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d writes expected 2", q0_addr.size()); end
        if (q0_addr.size() == 2) begin
            checks++; if (q0_addr[0] !== 32'h0 || q0_data[0] !== 32'h0050_0093) begin errors++; $display("[TB] FAIL b2b_w0: got %h/%h expected 00000000/00500093", q0_addr[0], q0_data[0]); end
            checks++; if (q0_addr[1] !== 32'h4 || q0_data[1] !== 32'h00A0_0113) begin errors++; $display("[TB] FAIL b2b_w1: got %h/%h expected 00000004/00a00113", q0_addr[1], q0_data[1]); end
        end
        checks++; if ({hold0, done0, err0} !== 3'b010) begin errors++; $display("[TB] FAIL b2b_done: got hold/done/err %b expected 010", {hold0, done0, err0}); end
        checks++; if (addr0 !== 32'h4) begin errors++; $display("[TB] FAIL b2b_hold_addr: got %h expected 00000004", addr0); end
    endtask

    task automatic test_zero_length;
        pulse_restart(0);
        q0_addr.delete(); q0_data.delete();
        send_word(0, 32'd0);
        send_byte(0, 8'h00);
        checks++; if ({hold0, done0, err0} !== 3'b010) begin errors++; $display("[TB] FAIL zero_good: got hold/done/err %b expected 010", {hold0, done0, err0}); end
        pulse_restart(0);
        send_word(0, 32'd0);
        send_byte(0, 8'h5A);
        checks++; if ({hold0, done0, err0, ready0} !== 4'b1010) begin errors++; $display("[TB] FAIL zero_bad: got hold/done/err/ready %b expected 1010", {hold0, done0, err0, ready0}); end
        checks++; if (q0_addr.size() != 0) begin errors++; $display("[TB] FAIL zero_writes: got %0d expected 0", q0_addr.size()); end
    endtask

    task automatic test_reset_midload;
        pulse_restart(0);
        q0_addr.delete(); q0_data.delete();
        send_word(0, 32'd1);
        send_byte(0, 8'hAA);
        send_byte(0, 8'hBB);
        #2 rst_n0 = 1'b0;
        #1;
        checks++; if (addr0 !== 32'h0 || wdata0 !== 32'h0) begin errors++; $display("[TB] FAIL midrst_data: got %h/%h expected 00000000/00000000", addr0, wdata0); end
        checks++; if ({we0, hold0, done0, err0, ready0} !== 5'b01001) begin errors++; $display("[TB] FAIL midrst_status: got we/hold/done/err/ready %b expected 01001", {we0, hold0, done0, err0, ready0}); end
        idle(2);
        rst_n0 = 1'b1;
        idle(1);
        send_word(0, 32'd1);
        send_word(0, 32'h1234_5678);
        send_byte(0, xor_word(32'h1234_5678));
        checks++; if (q0_addr.size() != 1) begin errors++; $display("[TB] FAIL midrst_count: got %0d writes expected 1", q0_addr.size()); end
        if (q0_addr.size() == 1) begin
            checks++; if (q0_addr[0] !== 32'h0 || q0_data[0] !== 32'h1234_5678) begin errors++; $display("[TB] FAIL midrst_write: got %h/%h expected 00000000/12345678", q0_addr[0], q0_data[0]); end
        end
        checks++; if (done0 !== 1'b1) begin errors++; $display("[TB] FAIL midrst_done: got %0b expected 1", done0); end
    endtask

    task automatic test_oversize;
        q4_addr.delete(); q4_data.delete();
        send_byte(1, 8'h05);
        send_byte(1, 8'h00);
        send_byte(1, 8'h00);
        checks++; if (err4 !== 1'b0) begin errors++; $display("[TB] FAIL over_early: got err %0b expected 0", err4); end
        send_byte(1, 8'h00);
        checks++; if ({err4, ready4, hold4, done4} !== 4'b1010) begin errors++; $display("[TB] FAIL over_err: got err/ready/hold/done %b expected 1010", {err4, ready4, hold4, done4}); end
        idle(2);
        checks++; if (q4_addr.size() != 0) begin errors++; $display("[TB] FAIL over_writes: got %0d expected 0", q4_addr.size()); end
    endtask

    task automatic test_restart_from_err;
        int hold_low;
        hold_low = 0;
        q4_addr.delete(); q4_data.delete();
        pulse_restart(1);
        checks++; if ({err4, ready4, hold4} !== 3'b011) begin errors++; $display("[TB] FAIL rerr_restart: got err/ready/hold %b expected 011", {err4, ready4, hold4}); end
        send_word(1, 32'd1);
        if (hold4 !== 1'b1) hold_low++;
        send_byte(1, 8'hEF);
        send_byte(1, 8'hBE);
        restart4 = 1'b1;
        idle(1);
        restart4 = 1'b0;
        if (hold4 !== 1'b1) hold_low++;
        send_byte(1, 8'hAD);
        send_byte(1, 8'hDE);
        if (hold4 !== 1'b1) hold_low++;
        checks++; if (hold_low != 0) begin errors++; $display("[TB] FAIL rerr_hold: got %0d samples with hold low expected 0", hold_low); end
        send_byte(1, xor_word(32'hDEAD_BEEF));
        checks++; if ({hold4, done4} !== 2'b01) begin errors++; $display("[TB] FAIL rerr_done: got hold/done %b expected 01", {hold4, done4}); end
        checks++; if (q4_addr.size() != 1) begin errors++; $display("[TB] FAIL rerr_count: got %0d writes expected 1", q4_addr.size()); end
        if (q4_addr.size() == 1) begin
            checks++; if (q4_addr[0] !== 32'h0000_1000 || q4_data[0] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rerr_write: got %h/%h expected 00001000/deadbeef", q4_addr[0], q4_data[0]); end
        end
    endtask

    task automatic test_max_depth;
        logic [31:0] words [4];
        logic [7:0]  cs;
        words[0] = 32'h1111_0001; words[1] = 32'h2222_0002;
        words[2] = 32'h3333_0003; words[3] = 32'h4444_0004;
        cs = 8'h00;
        pulse_restart(1);
        q4_addr.delete(); q4_data.delete();
        send_word(1, 32'd4);
        for (int i = 0; i < 4; i++) begin
            send_word(1, words[i]);
            cs = cs ^ xor_word(words[i]);
        end
        send_byte(1, cs);
        checks++; if ({done4, err4} !== 2'b10) begin errors++; $display("[TB] FAIL max_done: got done/err %b expected 10", {done4, err4}); end
        checks++; if (q4_addr.size() != 4) begin errors++; $display("[TB] FAIL max_count: got %0d writes expected 4", q4_addr.size()); end
        for (int i = 0; i < 4 && i < q4_addr.size(); i++) begin
            checks++;
            if (q4_addr[i] !== 32'h0000_1000 + 32'(4 * i) || q4_data[i] !== words[i]) begin
                errors++;
                $display("[TB] FAIL max_w%0d: got %h/%h expected %h/%h", i, q4_addr[i], q4_data[i], 32'h0000_1000 + 32'(4 * i), words[i]);
            end
        end
    endtask

    initial begin
        rst_n0 = 1'b0; rx_valid0 = 1'b0; rx_data0 = 8'h00; restart0 = 1'b0;
        rst_n4 = 1'b0; rx_valid4 = 1'b0; rx_data4 = 8'h00; restart4 = 1'b0;
        idle(2);
        test_reset;
        rst_n0 = 1'b1;
        rst_n4 = 1'b1;
        idle(1);
        test_single_word;
        test_back_to_back;
        test_zero_length;
        test_reset_midload;
        test_oversize;
        test_restart_from_err;
        test_max_depth;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
